// File: rtl/alu_input_ctrl_if.sv
// Bus bundle for the ALU input controller: raw pushbuttons and switches in,
// operand/opcode registers and debounced key events out.
interface alu_input_ctrl_if;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  opcode;
  logic [3:0]  key_evt;
  logic [7:0]  load_count;

  modport master (
    output key_n,
    output sw,
    input  op1,
    input  op2,
    input  opcode,
    input  key_evt,
    input  load_count
  );

  modport slave (
    input  key_n,
    input  sw,
    output op1,
    output op2,
    output opcode,
    output key_evt,
    output load_count
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// ALU input controller: synchronizes and debounces four pushbuttons, turns
// presses into one-cycle events and applies LOAD/STEP/CLEAR/SWAP to the
// operand and opcode registers.
module alu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int OPCODE_MAX      = 15
) (
  input logic          CLK,
  input logic          nRST,
  alu_input_ctrl_if.slave bus
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     OP_MAX = 4'(OPCODE_MAX);

  localparam int K_LOAD  = 0;
  localparam int K_STEP  = 1;
  localparam int K_CLEAR = 2;
  localparam int K_SWAP  = 3;

  logic [3:0]          key_s1_q, key_s2_q;
  logic [17:0]         sw_s1_q, sw_s2_q;
  logic [3:0]          deb_q, deb_d;
  logic [3:0]          deb_dly_q;
  logic [3:0][CW-1:0]  cnt_q, cnt_d;
  logic [3:0]          evt_q, evt_d;
  logic [31:0]         op1_q, op1_d;
  logic [31:0]         op2_q, op2_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [7:0]          load_count_q, load_count_d;
  logic [31:0]         sw_val;

  // Two-flop synchronizers; keys idle released (1), switches idle 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= bus.key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= bus.sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Per-key debouncer: any sample matching the accepted state restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (key_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        deb_d[i] = key_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Event fires the cycle after the accepted state has fallen.
    evt_d = deb_dly_q & ~deb_q;
  end

  // Debouncer state, delayed copy for edge detection, and the event register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      deb_q     <= 4'hF;
      deb_dly_q <= 4'hF;
      cnt_q     <= '0;
      evt_q     <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
    end
  end

  assign sw_val = {{16{sw_s2_q[16]}}, sw_s2_q[15:0]};

  // Event actions: CLEAR wins, SWAP beats LOAD on operands, STEP is independent.
  always_comb begin
    op1_d        = op1_q;
    op2_d        = op2_q;
    opcode_d     = opcode_q;
    load_count_d = load_count_q;
    if (evt_q[K_CLEAR]) begin
      op1_d        = '0;
      op2_d        = '0;
      opcode_d     = '0;
      load_count_d = '0;
    end else begin
      if (evt_q[K_SWAP]) begin
        op1_d = op2_q;
        op2_d = op1_q;
      end else if (evt_q[K_LOAD]) begin
        if (sw_s2_q[17]) op1_d = sw_val;
        else             op2_d = sw_val;
        load_count_d = load_count_q + 8'd1;
      end
      if (evt_q[K_STEP]) begin
        opcode_d = (opcode_q == OP_MAX) ? 4'd0 : opcode_q + 4'd1;
      end
    end
  end

  // Operand, opcode and load counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
      load_count_q <= '0;
    end else begin
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opcode_q     <= opcode_d;
      load_count_q <= load_count_d;
    end
  end

  assign bus.op1        = op1_q;
  assign bus.op2        = op2_q;
  assign bus.opcode     = opcode_q;
  assign bus.key_evt    = evt_q;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Bench for alu_input_ctrl: directed scenarios plus random key/switch traffic,
// checked every cycle against a window-based reference model.
module tb_alu_input_ctrl;
  localparam int D     = 4;
  localparam int OPMAX = 15;
  localparam int HN    = D + 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  alu_input_ctrl_if intf();

  alu_input_ctrl #(.DEBOUNCE_CYCLES(D), .OPCODE_MAX(OPMAX)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (intf)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int evt_cnt [4];
  bit model_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a key's accepted state flips once the last D samples seen
  // by the debouncer (raw value two edges old) all disagree with it.
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_opcode, m_deb, m_evt, m_fall;
  logic [7:0]  m_lc;
  logic [3:0]  kh [HN];
  logic [17:0] sh [HN];

  always @(posedge CLK or negedge nRST) begin
    logic [17:0] s;
    logic [31:0] val, t;
    logic [3:0]  fall;
    bit          all_diff;
    if (!nRST) begin
      m_op1 = 0; m_op2 = 0; m_opcode = 0; m_lc = 0;
      m_deb = 4'hF; m_evt = 0; m_fall = 0;
      for (int i = 0; i < HN; i++) begin kh[i] = 4'hF; sh[i] = '0; end
    end else begin
      s   = sh[1];
      val = {{16{s[16]}}, s[15:0]};
      if (m_evt[2]) begin
        m_op1 = 0; m_op2 = 0; m_opcode = 0; m_lc = 0;
      end else begin
        if (m_evt[3]) begin
          t = m_op1; m_op1 = m_op2; m_op2 = t;
        end else if (m_evt[0]) begin
          if (s[17]) m_op1 = val; else m_op2 = val;
          m_lc = m_lc + 8'd1;
        end
        if (m_evt[1]) m_opcode = (m_opcode == OPMAX) ? 4'd0 : m_opcode + 4'd1;
      end
      m_evt = m_fall;
      fall  = 0;
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (kh[1+j][k] == m_deb[k]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_deb[k]) fall[k] = 1'b1;
          m_deb[k] = ~m_deb[k];
        end
      end
      m_fall = fall;
      for (int i = HN - 1; i > 0; i--) begin kh[i] = kh[i-1]; sh[i] = sh[i-1]; end
      kh[0] = intf.key_n;
      sh[0] = intf.sw;
    end
  end

  // Per-cycle comparison against the model, plus event counting.
  always @(posedge CLK) begin
    #2;
    if (model_on) begin
      check("op1", intf.op1, m_op1);
      check("op2", intf.op2, m_op2);
      check("opcode", {28'd0, intf.opcode}, {28'd0, m_opcode});
      check("key_evt", {28'd0, intf.key_evt}, {28'd0, m_evt});
      check("load_count", {24'd0, intf.load_count}, {24'd0, m_lc});
    end
    for (int k = 0; k < 4; k++) if (intf.key_evt[k] === 1'b1) evt_cnt[k]++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr_evt();
    for (int k = 0; k < 4; k++) evt_cnt[k] = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    #1 nRST = 1'b0;
    idle(n);
    #1 nRST = 1'b1;
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int rel);
    @(negedge CLK);
    intf.key_n = ~mask;
    idle(hold);
    intf.key_n = 4'hF;
    idle(rel);
  endtask

  task automatic load(input logic [17:0] s);
    @(negedge CLK);
    intf.sw = s;
    idle(3);
    press(4'b0001, D + 4, D + 4);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_op1"}, intf.op1, 32'd0);
    check({tag, "_op2"}, intf.op2, 32'd0);
    check({tag, "_opcode"}, {28'd0, intf.opcode}, 32'd0);
    check({tag, "_evt"}, {28'd0, intf.key_evt}, 32'd0);
    check({tag, "_lc"}, {24'd0, intf.load_count}, 32'd0);
  endtask

  initial begin
    intf.key_n = 4'hF;
    intf.sw    = '0;
    clr_evt();
    idle(2);
    model_on = 1'b1;
    check_zero("reset");
    #1 nRST = 1'b1;
    idle(2);

    // Sign-extended load into op1
    clr_evt();
    @(negedge CLK); intf.sw = 18'h3_8001;
    idle(3);
    press(4'b0001, 20, 10);
    check("r028_op1", intf.op1, 32'hFFFF_8001);
    check("r028_op2", intf.op2, 32'd0);
    check("r028_lc", {24'd0, intf.load_count}, 32'd1);
    check("r028_evt0", evt_cnt[0], 32'd1);

    // Bouncing STEP key never qualifies
    do_reset(2);
    clr_evt();
    for (int i = 0; i < 10; i++) begin
      intf.key_n = 4'b1101; idle(2);
      intf.key_n = 4'hF;    idle(2);
    end
    idle(10);
    check("r029_evt1", evt_cnt[1], 32'd0);
    check("r029_opcode", {28'd0, intf.opcode}, 32'd0);

    // Opcode wrap at OPCODE_MAX
    do_reset(2);
    for (int i = 0; i < OPMAX; i++) press(4'b0010, D + 4, D + 4);
    check("r030_max", {28'd0, intf.opcode}, 32'd15);
    press(4'b0010, D + 4, D + 4);
    check("r030_wrap", {28'd0, intf.opcode}, 32'd0);
    press(4'b0010, D + 4, D + 4);
    check("r030_one", {28'd0, intf.opcode}, 32'd1);

    // SWAP together with STEP
    do_reset(2);
    load({2'b10, 16'd5});
    load({2'b00, 16'd9});
    check("r031_pre_op1", intf.op1, 32'd5);
    check("r031_pre_op2", intf.op2, 32'd9);
    press(4'b1010, D + 4, D + 4);
    check("r031_op1", intf.op1, 32'd9);
    check("r031_op2", intf.op2, 32'd5);
    check("r031_opcode", {28'd0, intf.opcode}, 32'd1);
    check("r031_lc", {24'd0, intf.load_count}, 32'd2);

    // CLEAR together with LOAD
    load({2'b10, 16'd7});
    check("r032_pre_op1", intf.op1, 32'd7);
    press(4'b0101, D + 4, D + 4);
    check_zero("r032");

    // Reset in the middle of a debounce, key held through release
    do_reset(2);
    @(negedge CLK); intf.sw = 18'h2_0003;
    idle(3);
    @(negedge CLK); intf.key_n = 4'hE;
    idle(3);
    #1 nRST = 1'b0;
    idle(3);
    check_zero("r033_inrst");
    clr_evt();
    #1 nRST = 1'b1;
    idle(D + 8);
    check("r033_evt0", evt_cnt[0], 32'd1);
    check("r033_lc", {24'd0, intf.load_count}, 32'd1);
    check("r033_op1", intf.op1, 32'd3);
    intf.key_n = 4'hF;
    idle(D + 4);

    // Random traffic: glitches, long holds, overlapping keys, odd resets
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
      @(negedge CLK);
      intf.sw    = 18'($urandom);
      intf.key_n = ~4'($urandom_range(0, 15));
      idle($urandom_range(1, 10));
      intf.key_n = 4'hF;
      if ($urandom_range(0, 3) == 0) intf.sw = 18'($urandom);
      idle($urandom_range(1, 10));
    end
    idle(D + 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
